// File: rtl/can_tx_en_arbiter.sv
// Shares one CAN transceiver TX path among NUM_REQ requesters: round-robin ownership,
// recessive guard windows around each owner, stuck-dominant watchdog, Avalon-MM control.
//
// state  | meaning
// IDLE   | bus released, driver off, waiting for enable && any request
// SETUP  | driver on, recessive guard before the owner drives
// ACTIVE | owner's tx_bit forwarded one clk late, watchdog armed
// HOLD   | driver on, recessive guard after the owner releases
// FAULT  | stuck dominant seen, driver off until the CPU clears fault
module can_tx_en_arbiter #(
    parameter int          NUM_REQ      = 2,
    parameter int          GUARD_CYCLES = 8,
    parameter logic [15:0] TIMEOUT_RST  = 16'd4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic [NUM_REQ-1:0] tx_bit,
    output logic [NUM_REQ-1:0] grant,
    output logic               can_tx,
    output logic               can_tx_en,
    output logic               irq,
    input  logic [1:0]         address,
    input  logic               chipselect,
    input  logic               write,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata
);
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1 = IW + 1;
    localparam int GW  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [IW:0]   NREQ       = IW1'(NUM_REQ);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    localparam logic [1:0] ADDR_STATUS   = 2'd0;
    localparam logic [1:0] ADDR_CONTROL  = 2'd1;
    localparam logic [1:0] ADDR_FAULTCLR = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [GW-1:0] guard_cnt, guard_next;
    logic [15:0]   dom_cnt, dom_next;
    logic [IW-1:0] ptr, ptr_next;
    logic [IW-1:0] owner, owner_next;
    logic [IW-1:0] pick;
    logic [NUM_REQ-1:0] rot;
    logic          wd_hit;
    logic          window_next;

    logic          enable;
    logic          irq_en;
    logic          fault;
    logic [15:0]   timeout;
    logic          reg_wr;
    logic          fault_clr;
    logic          busy;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NREQ) s = s - NREQ;
        return s[IW-1:0];
    endfunction

    // Requests rotated so rot[0] is the requester at the pointer; lowest set bit wins.
    always_comb begin
        rot  = '0;
        pick = ptr;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req[wrap_add(ptr, IW'(i))];
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pick = wrap_add(ptr, IW'(i));
        end
    end

    always_comb begin
        state_next = state;
        guard_next = guard_cnt;
        ptr_next   = ptr;
        owner_next = owner;
        dom_next   = '0;
        wd_hit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (|req)) begin
                    state_next = ST_SETUP;
                    guard_next = GUARD_LOAD;
                    owner_next = pick;
                    ptr_next   = wrap_add(pick, IW'(1));
                end
            end
            ST_SETUP: begin
                if (guard_cnt == '0) state_next = ST_ACTIVE;
                else guard_next = guard_cnt - 1'b1;
            end
            ST_ACTIVE: begin
                if (!can_tx) dom_next = (dom_cnt == 16'hFFFF) ? dom_cnt : dom_cnt + 16'd1;
                wd_hit = !can_tx && (timeout != 16'd0) && (dom_next == timeout);
                // Watchdog takes priority over a release in the same cycle.
                if (wd_hit) begin
                    state_next = ST_FAULT;
                end else if (done[owner] || !req[owner]) begin
                    state_next = ST_HOLD;
                    guard_next = GUARD_LOAD;
                end
            end
            ST_HOLD: begin
                if (guard_cnt == '0) state_next = ST_IDLE;
                else guard_next = guard_cnt - 1'b1;
            end
            ST_FAULT: begin
                if (!fault) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign window_next = (state_next == ST_SETUP) || (state_next == ST_ACTIVE) ||
                         (state_next == ST_HOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            guard_cnt <= '0;
            dom_cnt   <= '0;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            can_tx    <= 1'b1;
            can_tx_en <= 1'b0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_next;
            dom_cnt   <= dom_next;
            ptr       <= ptr_next;
            owner     <= owner_next;
            grant     <= window_next ? (NUM_REQ'(1) << owner_next) : '0;
            can_tx    <= (state_next == ST_ACTIVE) ? tx_bit[owner_next] : 1'b1;
            can_tx_en <= window_next;
        end
    end

    assign reg_wr       = chipselect && write;
    assign fault_clr    = reg_wr && (address == ADDR_FAULTCLR) && writedata[0];
    assign busy         = (state != ST_IDLE);
    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:  rd_mux = {16'h0, 8'(owner), 1'b0, state, 1'b0, fault, busy, can_tx_en};
            ADDR_CONTROL: rd_mux = {30'h0, irq_en, enable};
            ADDR_TIMEOUT: rd_mux = {16'h0, timeout};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            fault    <= 1'b0;
            timeout  <= TIMEOUT_RST;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (reg_wr && (address == ADDR_CONTROL)) begin
                enable <= writedata[0];
                irq_en <= writedata[1];
            end
            if (reg_wr && (address == ADDR_TIMEOUT)) timeout <= writedata[15:0];
            // A watchdog hit in the same cycle as a clear leaves fault set.
            if (wd_hit) fault <= 1'b1;
            else if (fault_clr) fault <= 1'b0;
            irq <= fault & irq_en;
            if (chipselect && !write) readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_can_tx_en_arbiter.sv
// Bench for can_tx_en_arbiter: register table through a read scoreboard, then
// hand-written ownership, watchdog, enable-drop, release and async-reset sequences.
module tb_can_tx_en_arbiter;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  tx_bit;
    logic [N-1:0]  grant;
    logic          can_tx;
    logic          can_tx_en;
    logic          irq;
    logic [1:0]    address;
    logic          chipselect;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t         vecs[$];
    sb_t          sb_q[$];
    logic [N-1:0] gq[$];

    always #5 clk = ~clk;

    can_tx_en_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(8), .TIMEOUT_RST(16'd4096)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .done       (done),
        .tx_bit     (tx_bit),
        .grant      (grant),
        .can_tx     (can_tx),
        .can_tx_en  (can_tx_en),
        .irq        (irq),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string nm);
        sb_t s;
        chipselect = 1'b1;
        write      = 1'b0;
        address    = a;
        s.exp  = e;
        s.name = nm;
        sb_q.push_back(s);
        tick();
        chipselect = 1'b0;
        s = sb_q.pop_front();
        chk(s.name, readdata, s.exp);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = '0;
        done       = '0;
        tx_bit     = '1;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = 2'd0;
        writedata  = '0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input logic [N-1:0] e, input string nm);
        int n;
        n = 0;
        while (grant !== e && n < 60) begin
            tick();
            n++;
        end
        chk(nm, grant, e);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int k;
        logic ok;

        vecs.push_back('{1'b0, 2'd0, 32'h0000_0000, "rst_status"});
        vecs.push_back('{1'b0, 2'd1, 32'h0000_0000, "rst_control"});
        vecs.push_back('{1'b0, 2'd3, 32'h0000_1000, "rst_timeout"});
        vecs.push_back('{1'b0, 2'd2, 32'h0000_0000, "rst_faultclr"});
        vecs.push_back('{1'b1, 2'd1, 32'h0000_0003, ""});
        vecs.push_back('{1'b0, 2'd1, 32'h0000_0003, "control_3"});
        vecs.push_back('{1'b1, 2'd3, 32'h0000_1234, ""});
        vecs.push_back('{1'b0, 2'd3, 32'h0000_1234, "timeout_1234"});
        vecs.push_back('{1'b1, 2'd3, 32'hABCD_0010, ""});
        vecs.push_back('{1'b0, 2'd3, 32'h0000_0010, "timeout_upper_dropped"});
        vecs.push_back('{1'b1, 2'd1, 32'hFFFF_FFFE, ""});
        vecs.push_back('{1'b0, 2'd1, 32'h0000_0002, "control_irq_en_only"});
        vecs.push_back('{1'b1, 2'd0, 32'hFFFF_FFFF, ""});
        vecs.push_back('{1'b0, 2'd0, 32'h0000_0000, "status_read_only"});
        vecs.push_back('{1'b1, 2'd2, 32'h0000_0001, ""});
        vecs.push_back('{1'b0, 2'd2, 32'h0000_0000, "faultclr_reads_0"});

        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_can_tx", can_tx, 1);
        chk("rst_can_tx_en", can_tx_en, 0);
        chk("rst_irq", irq, 0);
        chk("rst_readdata", readdata, 0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else bus_read(vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // single requester: guard lengths and one-clk tx delay
        do_reset();
        bus_write(2'd1, 32'h1);
        req    = 2'b01;
        tx_bit = 2'b00;
        chk("t1_no_grant_before_edge", grant, 0);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_setup_en", can_tx_en, 1);
        n = 0;
        while (can_tx_en && can_tx && n < 40) begin
            n++;
            tick();
        end
        chk("t1_setup_len", n, 8);
        chk("t1_active_dominant", can_tx, 0);
        tx_bit = 2'b01;
        tick();
        chk("t1_delay_rec", can_tx, 1);
        tx_bit = 2'b00;
        tick();
        chk("t1_delay_dom", can_tx, 0);
        bus_read(2'd0, 32'h0000_0023, "t1_status_active");
        done = 2'b01;
        req  = 2'b00;
        tick();
        done = 2'b00;
        n = 0;
        while (can_tx_en && n < 40) begin
            chk("t1_hold_recessive", can_tx, 1);
            n++;
            tick();
        end
        chk("t1_hold_len", n, 8);
        chk("t1_idle_grant", grant, 0);

        // both requesting: round-robin alternation
        do_reset();
        bus_write(2'd1, 32'h1);
        tx_bit = 2'b11;
        req    = 2'b11;
        for (int w = 0; w < 4; w++) gq.push_back((w % 2 == 0) ? 2'b01 : 2'b10);
        for (int w = 0; w < 4; w++) begin
            logic [N-1:0] e;
            e = gq.pop_front();
            wait_grant(e, "t2_grant");
            chk("t2_onehot", $countones(grant), 1);
            repeat (10) tick();
            if (w == 1) bus_read(2'd0, 32'h0000_0123, "t2_status_owner1");
            done = e;
            tick();
            done = 2'b00;
            wait_grant(2'b00, "t2_release");
        end

        // watchdog at 16 dominant cycles, irq, fault clear
        do_reset();
        bus_write(2'd3, 32'd16);
        bus_write(2'd1, 32'h3);
        tx_bit = 2'b00;
        req    = 2'b01;
        wait_grant(2'b01, "t3_grant");
        n = 0;
        k = 0;
        while (can_tx_en && k < 100) begin
            if (!can_tx) n++;
            k++;
            tick();
        end
        chk("t3_dominant_cycles", n, 16);
        chk("t3_en_off", can_tx_en, 0);
        chk("t3_can_tx_rec", can_tx, 1);
        chk("t3_grant_off", grant, 0);
        tick();
        chk("t3_irq", irq, 1);
        bus_read(2'd0, 32'h0000_0046, "t3_status_fault");
        req = 2'b00;
        bus_write(2'd2, 32'h1);
        tick();
        chk("t3_irq_cleared", irq, 0);
        bus_read(2'd0, 32'h0000_0000, "t3_status_idle");

        // done in the same cycle as the watchdog hit
        do_reset();
        bus_write(2'd3, 32'd4);
        bus_write(2'd1, 32'h1);
        tx_bit = 2'b00;
        req    = 2'b01;
        wait_grant(2'b01, "t3b_grant");
        n = 0;
        while (can_tx && n < 40) begin
            n++;
            tick();
        end
        repeat (3) tick();
        done = 2'b01;
        tick();
        done = 2'b00;
        chk("t3b_fault_wins_en", can_tx_en, 0);
        chk("t3b_fault_wins_grant", grant, 0);
        tick();
        chk("t3b_irq_masked", irq, 0);
        bus_read(2'd0, 32'h0000_0046, "t3b_status_fault");

        // enable dropped mid-window
        do_reset();
        bus_write(2'd1, 32'h1);
        tx_bit = 2'b11;
        req    = 2'b11;
        wait_grant(2'b01, "t4_grant");
        repeat (10) tick();
        bus_write(2'd1, 32'h0);
        chk("t4_still_en", can_tx_en, 1);
        chk("t4_still_grant", grant, 2'b01);
        done = 2'b01;
        tick();
        done = 2'b00;
        n = 0;
        while (can_tx_en && n < 40) begin
            n++;
            tick();
        end
        chk("t4_hold_len", n, 8);
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (grant !== 2'b00 || can_tx_en !== 1'b0) ok = 1'b0;
        end
        chk("t4_no_regrant", ok, 1);

        // non-owner done ignored, req drop releases, async reset
        do_reset();
        bus_write(2'd1, 32'h1);
        tx_bit = 2'b00;
        req    = 2'b11;
        wait_grant(2'b01, "t5_grant");
        repeat (10) tick();
        done = 2'b10;
        tick();
        done = 2'b00;
        repeat (3) tick();
        chk("t5_other_done_grant", grant, 2'b01);
        chk("t5_other_done_active", can_tx, 0);
        req = 2'b10;
        tick();
        chk("t5_req_drop_hold_rec", can_tx, 1);
        chk("t5_req_drop_hold_en", can_tx_en, 1);
        wait_grant(2'b10, "t5_grant_next");
        repeat (10) tick();
        chk("t5_active_dom", can_tx, 0);
        chk("t5_active_en", can_tx_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_en", can_tx_en, 0);
        chk("t5_async_can_tx", can_tx, 1);
        chk("t5_async_grant", grant, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
